uart_prog_loader: RTL
=====================

Name: uart_prog_loader

Overview:
- Upstream loader for the 4-bit CPU's 16x8 program RAM. Receives a program image over the USB-UART line (8N1) and writes it byte by byte into the RAM.
- Holds the CPU halted while a load is in progress.
- Sits between the board's UART RX pin and the CPU's RAM write port and halt input.

Parameters:
- CLK_HZ, 27000000, system clock frequency in Hz.
- BAUD, 115200, UART bit rate. DIV = CLK_HZ/BAUD, integer-truncated; 234 at defaults.
- DEPTH, 16, number of program bytes per image. Must be a power of 2 and at least 2.
- SYNC, 8'hA5, byte that starts a load.
- TIMEOUT_CLKS, 2700000, maximum idle gap between bytes inside a load (100 ms at defaults).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  UART receive line, asynchronous, idle high.
- wr_en  out  1  one-cycle RAM write strobe.
- wr_addr  out  $clog2(DEPTH)  RAM write address.
- wr_data  out  8  RAM write data.
- halt  out  1  high while a load is in progress; the CPU must not step while it is high.
- done  out  1  one-cycle pulse on a successful load.
- err  out  1  sticky error flag; cleared by rst or by reception of the next SYNC byte.

Behaviour:
- Reset (rst high at a clk edge) forces:
  - wr_en=0, wr_addr=0, wr_data=0, halt=0, done=0, err=0;
  - FSM to IDLE and UART receiver to RX_IDLE.
  - rst mid-load aborts the load; RAM bytes already written stay written.
- rx input: 2-flop synchronizer, all logic uses the synchronized value (rxs). rxs lags rx by 2 clk.
- UART receiver states: RX_IDLE, RX_START, RX_DATA, RX_STOP.
  - RX_IDLE -> RX_START when rxs is 0; baud counter cleared.
  - RX_START: sample at count DIV/2-1.
    - rxs=1 there is a glitch -> RX_IDLE, no byte.
    - Otherwise counter restarts -> RX_DATA.
  - RX_DATA: 8 samples, each at count DIV-1, LSB first -> RX_STOP.
  - RX_STOP: sample at count DIV-1.
    - rxs=1: byte_valid for 1 clk with the shifted byte.
    - rxs=0: frame_err for 1 clk, byte discarded.
    - Either way -> RX_IDLE on the next clk.
  - Back-to-back frames with no idle time between them must be received.
- Loader FSM states: IDLE, DATA, CHECK.
  - IDLE:
    - byte_valid with byte==SYNC -> DATA; halt=1, err=0, addr=0, sum=0.
    - Any other byte, or a frame_err, is ignored.
  - DATA, on byte_valid:
    - wr_data=byte, wr_addr=addr, and wr_en=1 on the next clk, for exactly 1 clk.
    - sum=(sum+byte) mod 256.
    - If addr==DEPTH-1 -> CHECK, otherwise addr+1.
  - CHECK, on byte_valid:
    - byte==sum: done=1 for 1 clk, halt=0 -> IDLE.
    - byte!=sum: err=1, halt=0 -> IDLE.
- Abort: frame_err, or TIMEOUT_CLKS clk with no byte_valid while in DATA or CHECK.
  - Sets err=1 and halt=0, FSM -> IDLE.
  - Bytes already written are not rolled back.
  - The timeout counter is cleared on every byte_valid and on entry to DATA.
- A SYNC-valued byte inside DATA is program data, not a restart.
- wr_addr and wr_data hold their last value while wr_en=0.
- halt rises on the clk after the SYNC byte_valid. It falls on the same clk that done pulses or err sets.
- done and wr_en are never high in the same cycle.

Test Plan:
Benches use CLK_HZ=1600000, BAUD=100000 (DIV=16) and TIMEOUT_CLKS=400.
- Nominal load: send A5, bytes 00..0F, then 78 (sum=0x78). Required:
  - 16 wr_en pulses, addr 0..15, data 00..0F.
  - done pulses once; err=0; halt high from 1 clk after the A5 stop sample until done.
- Bad checksum: same image with checksum 77. Required: 16 writes, no done, err=1, halt=0; err clears on the next A5.
- Timeout: send A5 and 5 bytes, then keep rx high for 500 clk. Required: err=1 and halt=0 after 400 clk; RAM addr 0..4 written; a fresh load then succeeds.
- Framing error: 3rd data byte with its stop bit driven 0. Required: no write for that byte, err=1, FSM IDLE. In IDLE the same event leaves err=0.
- Start glitch and reset:
  - A 4-clk low pulse on rx produces no byte.
  - rst asserted after the 8th data byte gives all outputs 0; the next A5 restarts the load at addr 0.
- Garbage before sync: bytes FF, 00, 5A, then a valid image. Required: only the image is written; done=1.

Source files
------------

// File: rtl/uart_prog_loader.sv
// uart_prog_loader
//   Receives a program image over an 8N1 UART line and writes it byte by
//   byte into the CPU's program RAM. The CPU is held halted for the length
//   of a load.
//   Frame on the line: SYNC, DEPTH data bytes, then one checksum byte equal
//   to the 8-bit sum of the data bytes.
//
// Ports
//   clk      system clock
//   rst      synchronous, active-high reset
//   rx       UART receive line (asynchronous, idle high)
//   wr_en    one-cycle RAM write strobe
//   wr_addr  RAM write address (holds its value while wr_en is low)
//   wr_data  RAM write data (holds its value while wr_en is low)
//   halt     high while a load is in progress
//   done     one-cycle pulse when a load finishes with a good checksum
//   err      sticky error flag; cleared by rst or by the next SYNC byte
module uart_prog_loader #(
    parameter int          CLK_HZ       = 27000000,
    parameter int          BAUD         = 115200,
    parameter int          DEPTH        = 16,
    parameter logic [7:0]  SYNC         = 8'hA5,
    parameter int          TIMEOUT_CLKS = 2700000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx,
    output logic                     wr_en,
    output logic [$clog2(DEPTH)-1:0] wr_addr,
    output logic [7:0]               wr_data,
    output logic                     halt,
    output logic                     done,
    output logic                     err
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DIV) + 1;
    localparam int TW  = $clog2(TIMEOUT_CLKS + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {IDLE, DATA, CHECK} ld_state_t;

    // ---------------- rx synchronizer ----------------
    logic rx_meta, rxs;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // ---------------- UART receiver ----------------
    rx_state_t     rx_q, rx_d;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          byte_valid, frame_err;
    logic          half_hit, full_hit;

    assign half_hit = (cnt == CW'(DIV / 2 - 1));
    assign full_hit = (cnt == CW'(DIV - 1));

    always_comb begin
        rx_d = rx_q;
        case (rx_q)
            RX_IDLE:  if (!rxs) rx_d = RX_START;
            // A start bit that is high again at mid-bit was a glitch.
            RX_START: if (half_hit) rx_d = rxs ? RX_IDLE : RX_DATA;
            RX_DATA:  if (full_hit && bit_idx == 3'd7) rx_d = RX_STOP;
            RX_STOP:  if (full_hit) rx_d = RX_IDLE;
            default:  rx_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_q       <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_q       <= rx_d;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_q)
                RX_IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                end
                RX_START: cnt <= half_hit ? '0 : cnt + CW'(1);
                RX_DATA: begin
                    if (full_hit) begin
                        cnt     <= '0;
                        shreg   <= {rxs, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (full_hit) begin
                        cnt        <= '0;
                        byte_valid <= rxs;
                        frame_err  <= ~rxs;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    // ---------------- loader FSM ----------------
    ld_state_t     st_q, st_d;
    logic [AW-1:0] addr;
    logic [7:0]    sum;
    logic [TW-1:0] tmo;
    logic          timeout, abort;

    assign timeout = (st_q != IDLE) && !byte_valid && (tmo == TW'(TIMEOUT_CLKS - 1));
    assign abort   = (st_q != IDLE) && (frame_err || timeout);

    always_comb begin
        st_d = st_q;
        case (st_q)
            IDLE:  if (byte_valid && shreg == SYNC) st_d = DATA;
            DATA: begin
                if (abort)                                        st_d = IDLE;
                else if (byte_valid && addr == AW'(DEPTH - 1))    st_d = CHECK;
            end
            CHECK: if (abort || byte_valid) st_d = IDLE;
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= IDLE;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            halt    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            addr    <= '0;
            sum     <= '0;
            tmo     <= '0;
        end else begin
            st_q  <= st_d;
            wr_en <= 1'b0;
            done  <= 1'b0;
            if (st_q == IDLE) begin
                if (byte_valid && shreg == SYNC) begin
                    halt <= 1'b1;
                    err  <= 1'b0;
                    addr <= '0;
                    sum  <= '0;
                    tmo  <= '0;
                end
            end else if (abort) begin
                err  <= 1'b1;
                halt <= 1'b0;
            end else if (byte_valid) begin
                tmo <= '0;
                if (st_q == DATA) begin
                    // A SYNC value here is ordinary program data.
                    wr_en   <= 1'b1;
                    wr_addr <= addr;
                    wr_data <= shreg;
                    sum     <= sum + shreg;
                    addr    <= addr + AW'(1);
                end else begin
                    if (shreg == sum) done <= 1'b1;
                    else              err  <= 1'b1;
                    halt <= 1'b0;
                end
            end else begin
                tmo <= tmo + TW'(1);
            end
        end
    end

endmodule
